ascon_dec_sched: RTL and testbench

- Job sequencer for the bit-serial Ascon decryption wrapper.
- Accepts one parallel decryption job (key, nonce, AD, ciphertext, expected tag) from a host over a valid/ready handshake.
- Resets the core, shifts the operands in MSB-first, issues start, waits for core completion, and deserializes the LSB-first plaintext/tag stream.
- Returns plaintext, a tag-match verdict and a timeout flag over a second valid/ready handshake. Sits between the host bus adapter and the decryption wrapper.

---
 rtl/ascon_dec_sched.sv | 189 ++++++++++++++++++
 tb/tb_ascon_dec_sched.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_dec_sched.sv
// Sequencer for one bit-serial Ascon decryption job: latch, core reset, MSB-first load, start, LSB-first drain.
// Latency: 1+N+2+S+128+1 cycles from cfg handshake to res_valid. No new job is taken until the result is consumed.
// Optional ASCON_SCHED_PERF_EN adds perf_cycles (last job latency) and perf_jobs (saturating job count).
module ascon_dec_sched #(
   parameter int K       = 128,
   parameter int L       = 32,
   parameter int Y       = 32,
   parameter int TIMEOUT = 4096
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cfg_valid,
   output logic         cfg_ready,
   input  logic [K-1:0] cfg_key,
   input  logic [127:0] cfg_nonce,
   input  logic [L-1:0] cfg_ad,
   input  logic [Y-1:0] cfg_ct,
   input  logic [127:0] cfg_tag,
   output logic         core_rst,
   output logic         key_so,
   output logic         nonce_so,
   output logic         ad_so,
   output logic         ct_so,
   output logic         start_o,
   input  logic         core_ready_i,
   input  logic         pt_si,
   input  logic         tag_si,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [Y-1:0] res_pt,
   output logic         res_pass,
`ifdef ASCON_SCHED_PERF_EN
   output logic [31:0]  perf_cycles,
   output logic [15:0]  perf_jobs,
`endif
   output logic         res_timeout
);

   localparam int N0 = (K > 128) ? K : 128;
   localparam int N1 = (N0 > L) ? N0 : L;
   localparam int N  = (N1 > Y) ? N1 : Y;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, CRST, LOAD, SETTLE, START, DRAIN, DONE} state_t;

   state_t         state, state_n;
   logic [7:0]     c;
   logic [TW-1:0]  tcnt;
   logic           accept;
   logic [K-1:0]   key_sh;
   logic [127:0]   nonce_sh;
   logic [L-1:0]   ad_sh;
   logic [Y-1:0]   ct_sh;
   logic [127:0]   tag_r, tag_cap, tag_nxt;
   logic [Y-1:0]   pt_cap, pt_nxt;

   assign accept = (state == IDLE) && cfg_valid && cfg_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (accept) state_n = CRST;
         CRST:    state_n = LOAD;
         LOAD:    if (int'(c) == N - 1) state_n = SETTLE;
         SETTLE:  if (c == 8'd1) state_n = START;
         START: begin
            // A ready seen on the last allowed cycle still wins over the abort.
            if (core_ready_i)                    state_n = DRAIN;
            else if (int'(tcnt) == TIMEOUT - 1)  state_n = DONE;
         end
         DRAIN:   if (c == 8'd127) state_n = DONE;
         DONE:    if (res_valid && res_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Plaintext and tag arrive LSB first, so they shift in from the top.
   always_comb begin
      pt_nxt  = pt_cap;
      tag_nxt = tag_cap >> 1;
      tag_nxt[127] = tag_si;
      if (int'(c) < Y) begin
         pt_nxt = pt_cap >> 1;
         pt_nxt[Y-1] = pt_si;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c           <= '0;
         tcnt        <= '0;
         cfg_ready   <= 1'b0;
         core_rst    <= 1'b0;
         start_o     <= 1'b0;
         res_valid   <= 1'b0;
         key_so      <= 1'b0;
         nonce_so    <= 1'b0;
         ad_so       <= 1'b0;
         ct_so       <= 1'b0;
         key_sh      <= '0;
         nonce_sh    <= '0;
         ad_sh       <= '0;
         ct_sh       <= '0;
         tag_r       <= '0;
         tag_cap     <= '0;
         pt_cap      <= '0;
         res_pt      <= '0;
         res_pass    <= 1'b0;
         res_timeout <= 1'b0;
      end else begin
         cfg_ready <= (state_n == IDLE);
         core_rst  <= (state_n == CRST);
         start_o   <= (state_n == START);
         res_valid <= (state_n == DONE);

         if (state_n != state)                     c <= '0;
         else if (state inside {LOAD, SETTLE, DRAIN}) c <= c + 8'd1;

         if (state != START) tcnt <= '0;
         else                tcnt <= tcnt + TW'(1);

         // Shift registers double as the operand latches; fields narrower than N run out to zeros.
         if (accept) begin
            key_sh   <= cfg_key;
            nonce_sh <= cfg_nonce;
            ad_sh    <= cfg_ad;
            ct_sh    <= cfg_ct;
            tag_r    <= cfg_tag;
         end else if (state_n == LOAD) begin
            key_sh   <= key_sh << 1;
            nonce_sh <= nonce_sh << 1;
            ad_sh    <= ad_sh << 1;
            ct_sh    <= ct_sh << 1;
         end

         if (state_n == LOAD) begin
            key_so   <= key_sh[K-1];
            nonce_so <= nonce_sh[127];
            ad_so    <= ad_sh[L-1];
            ct_so    <= ct_sh[Y-1];
         end else begin
            key_so   <= 1'b0;
            nonce_so <= 1'b0;
            ad_so    <= 1'b0;
            ct_so    <= 1'b0;
         end

         if (state == DRAIN) begin
            tag_cap <= tag_nxt;
            pt_cap  <= pt_nxt;
         end

         if (state == DRAIN && state_n == DONE) begin
            res_pt      <= pt_nxt;
            res_pass    <= (tag_nxt == tag_r);
            res_timeout <= 1'b0;
         end else if (state == START && state_n == DONE) begin
            res_pt      <= '0;
            res_pass    <= 1'b0;
            res_timeout <= 1'b1;
         end
      end
   end

`ifdef ASCON_SCHED_PERF_EN
   logic [31:0] pcnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt        <= '0;
         perf_cycles <= '0;
         perf_jobs   <= '0;
      end else begin
         if (accept)                               pcnt <= 32'd1;
         else if (state != IDLE && state != DONE)  pcnt <= pcnt + 32'd1;
         if (state != DONE && state_n == DONE) begin
            perf_cycles <= pcnt + 32'd1;
            if (perf_jobs != 16'hFFFF) perf_jobs <= perf_jobs + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ascon_dec_sched.sv
// Directed bench for ascon_dec_sched with a behavioural core that answers start and streams a reference pt/tag.
module tb_ascon_dec_sched;
   localparam int K  = 128;
   localparam int L  = 32;
   localparam int Y  = 32;
   localparam int TO = 16;

   localparam logic [127:0] REF_KEY   = 128'h000102030405060708090A0B0C0D0E0F;
   localparam logic [127:0] REF_NONCE = 128'h101112131415161718191A1B1C1D1E1F;
   localparam logic [31:0]  REF_AD    = 32'h41534344;
   localparam logic [31:0]  REF_CT    = 32'h9C4F03A7;
   localparam logic [31:0]  REF_PT    = 32'h6173636F;
   localparam logic [127:0] REF_TAG   = 128'hD3A15E078B24C6F910E27A5B3C8D4F61;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         cfg_valid = 1'b0;
   logic         cfg_ready;
   logic [K-1:0] cfg_key = '0;
   logic [127:0] cfg_nonce = '0;
   logic [L-1:0] cfg_ad = '0;
   logic [Y-1:0] cfg_ct = '0;
   logic [127:0] cfg_tag = '0;
   logic         core_rst, key_so, nonce_so, ad_so, ct_so, start_o;
   logic         core_ready_i = 1'b0;
   logic         pt_si = 1'b0;
   logic         tag_si = 1'b0;
   logic         res_valid;
   logic         res_ready = 1'b0;
   logic [Y-1:0] res_pt;
   logic         res_pass, res_timeout;

   int passed = 0;
   int total  = 0;

   int           lat, st, cr;
   logic [127:0] ko, no, ao, co;

   always #5 clk = ~clk;

   ascon_dec_sched #(.K(K), .L(L), .Y(Y), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_key(cfg_key), .cfg_nonce(cfg_nonce), .cfg_ad(cfg_ad), .cfg_ct(cfg_ct), .cfg_tag(cfg_tag),
      .core_rst(core_rst), .key_so(key_so), .nonce_so(nonce_so), .ad_so(ad_so), .ct_so(ct_so),
      .start_o(start_o), .core_ready_i(core_ready_i), .pt_si(pt_si), .tag_si(tag_si),
      .res_valid(res_valid), .res_ready(res_ready), .res_pt(res_pt),
      .res_pass(res_pass), .res_timeout(res_timeout)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got hang expected completion");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic consume;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   // Drives one job and plays the core; ready_delay<0 means core never answers, abort_d>=0 asserts rst at that DRAIN cycle.
   task automatic run_job(input logic [127:0] key, input logic [127:0] nonce, input logic [31:0] ad,
                          input logic [31:0] ct, input logic [127:0] tag, input int ready_delay,
                          input int abort_d);
      int cyc;
      int drain_c;
      logic [31:0]  pt_v;
      logic [127:0] tag_v;
      pt_v = REF_PT;
      tag_v = REF_TAG;
      lat = -1; st = 0; cr = 0;
      ko = '0; no = '0; ao = '0; co = '0;
      for (int i = 0; i < 10 && !cfg_ready; i++) tick();
      cfg_key = key; cfg_nonce = nonce; cfg_ad = ad; cfg_ct = ct; cfg_tag = tag;
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      cyc = 1;
      drain_c = -1;
      while (cyc < 2000) begin
         if (core_rst) cr++;
         if (cyc >= 2 && cyc < 130) begin
            ko = {ko[126:0], key_so};
            no = {no[126:0], nonce_so};
            ao = {ao[126:0], ad_so};
            co = {co[126:0], ct_so};
         end
         core_ready_i = 1'b0;
         pt_si = 1'b0;
         tag_si = 1'b0;
         if (drain_c >= 0 && drain_c == abort_d) begin
            rst = 1'b1;
            #1;
            break;
         end
         if (drain_c >= 0 && drain_c < 128) begin
            pt_si  = (drain_c < 32) ? pt_v[5'(drain_c)] : 1'b0;
            tag_si = tag_v[7'(drain_c)];
            drain_c++;
         end
         if (start_o) begin
            st++;
            if (ready_delay >= 0 && st == ready_delay + 1) begin
               core_ready_i = 1'b1;
               drain_c = 0;
            end
         end
         if (res_valid) begin
            lat = cyc;
            break;
         end
         tick();
         cyc++;
      end
      core_ready_i = 1'b0;
      pt_si = 1'b0;
      tag_si = 1'b0;
   endtask

   task automatic test_reset;
      logic [40:0] outs;
      repeat (2) @(posedge clk);
      #1;
      outs = {cfg_ready, core_rst, key_so, nonce_so, ad_so, ct_so, start_o, res_valid, res_pass, res_timeout, res_pt};
      total++;
      if (outs !== 41'h0) $display("FAIL reset_outputs: got %h expected %h", outs, 41'h0);
      else passed++;
      rst = 1'b0;
      tick();
      total++;
      if (cfg_ready !== 1'b1) $display("FAIL reset_cfg_ready: got %b expected 1", cfg_ready);
      else passed++;
   endtask

   task automatic test_golden_job;
      run_job(REF_KEY, REF_NONCE, REF_AD, REF_CT, REF_TAG, 2, -1);
      total++; if (lat !== 263) $display("FAIL golden_latency: got %0d expected 263", lat); else passed++;
      total++; if (st !== 3) $display("FAIL golden_start_cycles: got %0d expected 3", st); else passed++;
      total++; if (cr !== 1) $display("FAIL golden_core_rst_pulse: got %0d expected 1", cr); else passed++;
      total++; if (res_pt !== REF_PT) $display("FAIL golden_pt: got %h expected %h", res_pt, REF_PT); else passed++;
      total++; if (res_pass !== 1'b1) $display("FAIL golden_pass: got %b expected 1", res_pass); else passed++;
      total++; if (res_timeout !== 1'b0) $display("FAIL golden_timeout: got %b expected 0", res_timeout); else passed++;
      total++; if (ko !== REF_KEY) $display("FAIL golden_key_stream: got %h expected %h", ko, REF_KEY); else passed++;
      total++; if (no !== REF_NONCE) $display("FAIL golden_nonce_stream: got %h expected %h", no, REF_NONCE); else passed++;
      total++; if (ao !== {REF_AD, 96'h0}) $display("FAIL golden_ad_stream: got %h expected %h", ao, {REF_AD, 96'h0}); else passed++;
      total++; if (co !== {REF_CT, 96'h0}) $display("FAIL golden_ct_stream: got %h expected %h", co, {REF_CT, 96'h0}); else passed++;
      consume();
   endtask

   task automatic test_tag_mismatch;
      run_job(REF_KEY, REF_NONCE, REF_AD, REF_CT, REF_TAG ^ 128'h1, 2, -1);
      total++; if (lat !== 263) $display("FAIL mismatch_latency: got %0d expected 263", lat); else passed++;
      total++; if (res_pass !== 1'b0) $display("FAIL mismatch_pass: got %b expected 0", res_pass); else passed++;
      total++; if (res_pt !== REF_PT) $display("FAIL mismatch_pt: got %h expected %h", res_pt, REF_PT); else passed++;
      total++; if (res_timeout !== 1'b0) $display("FAIL mismatch_timeout: got %b expected 0", res_timeout); else passed++;
      consume();
   endtask

   task automatic test_timeout;
      run_job(REF_KEY, REF_NONCE, REF_AD, REF_CT, REF_TAG, -1, -1);
      total++; if (st !== 16) $display("FAIL timeout_start_cycles: got %0d expected 16", st); else passed++;
      total++; if (lat !== 148) $display("FAIL timeout_latency: got %0d expected 148", lat); else passed++;
      total++; if (res_timeout !== 1'b1) $display("FAIL timeout_flag: got %b expected 1", res_timeout); else passed++;
      total++; if (res_pass !== 1'b0) $display("FAIL timeout_pass: got %b expected 0", res_pass); else passed++;
      total++; if (res_pt !== 32'h0) $display("FAIL timeout_pt: got %h expected 0", res_pt); else passed++;
      consume();
   endtask

   task automatic test_load_order;
      logic [127:0] k;
      k = 128'h80000000000000000000000000000001;
      run_job(k, REF_NONCE, 32'h80000001, REF_CT, REF_TAG, 0, -1);
      total++; if (ao !== {32'h80000001, 96'h0}) $display("FAIL load_ad_order: got %h expected %h", ao, {32'h80000001, 96'h0}); else passed++;
      total++; if (ko[127] !== 1'b1) $display("FAIL load_key_msb_first: got %b expected 1", ko[127]); else passed++;
      total++; if (ko !== k) $display("FAIL load_key_stream: got %h expected %h", ko, k); else passed++;
      total++; if (lat !== 261) $display("FAIL load_latency: got %0d expected 261", lat); else passed++;
      consume();
   endtask

   task automatic test_backpressure;
      int errs;
      run_job(REF_KEY, REF_NONCE, REF_AD, REF_CT, REF_TAG, 5, -1);
      total++; if (lat !== 266) $display("FAIL bp_latency: got %0d expected 266", lat); else passed++;
      errs = 0;
      for (int i = 0; i < 50; i++) begin
         cfg_valid = (i == 10);
         tick();
         if (res_valid !== 1'b1 || res_pt !== REF_PT || res_pass !== 1'b1 || res_timeout !== 1'b0 ||
             cfg_ready !== 1'b0 || core_rst !== 1'b0)
            errs++;
      end
      cfg_valid = 1'b0;
      total++; if (errs !== 0) $display("FAIL bp_hold_stable: got %0d bad cycles expected 0", errs); else passed++;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      total++; if (res_valid !== 1'b0) $display("FAIL bp_release_valid: got %b expected 0", res_valid); else passed++;
      total++; if (cfg_ready !== 1'b1) $display("FAIL bp_release_idle: got %b expected 1", cfg_ready); else passed++;
      errs = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (core_rst !== 1'b0) errs++;
      end
      total++; if (errs !== 0) $display("FAIL bp_ignored_job: got %0d core_rst cycles expected 0", errs); else passed++;
   endtask

   task automatic test_reset_mid_drain;
      logic [40:0] outs;
      int seen;
      run_job(REF_KEY, REF_NONCE, REF_AD, REF_CT, REF_TAG, 2, 60);
      outs = {cfg_ready, core_rst, key_so, nonce_so, ad_so, ct_so, start_o, res_valid, res_pass, res_timeout, res_pt};
      total++; if (outs !== 41'h0) $display("FAIL abort_outputs: got %h expected %h", outs, 41'h0); else passed++;
      total++; if (lat !== -1) $display("FAIL abort_early_result: got %0d expected -1", lat); else passed++;
      repeat (2) tick();
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (res_valid) seen++;
      end
      total++; if (seen !== 0) $display("FAIL abort_no_result: got %0d valid cycles expected 0", seen); else passed++;
      run_job(REF_KEY, REF_NONCE, REF_AD, REF_CT, REF_TAG, 1, -1);
      total++; if (lat !== 262) $display("FAIL after_abort_latency: got %0d expected 262", lat); else passed++;
      total++; if (res_pass !== 1'b1) $display("FAIL after_abort_pass: got %b expected 1", res_pass); else passed++;
      total++; if (res_pt !== REF_PT) $display("FAIL after_abort_pt: got %h expected %h", res_pt, REF_PT); else passed++;
      consume();
   endtask

   initial begin
      test_reset();
      test_golden_job();
      test_tag_mismatch();
      test_timeout();
      test_load_order();
      test_backpressure();
      test_reset_mid_drain();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
